// File: rtl/queue_2048_split_reader_pkg.sv
// queue_split_pkg: shared definitions for the 2048-bit queue width splitter.
// Contents:
//   split_state_e  - drain FSM state (IDLE, DRAIN)
//   beats_f        - number of narrow beats per wide word
//   cnt_w_f        - width of the beat counter for a given beat count
//   DEF_IN_W/DEF_OUT_W - default wide/narrow widths
package queue_split_pkg;

  localparam int DEF_IN_W  = 2048;
  localparam int DEF_OUT_W = 256;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } split_state_e;

  function automatic int beats_f(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // A counter is never narrower than one bit, even for degenerate beat counts.
  function automatic int cnt_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/queue_2048_split_reader_if.sv
// queue_2048_split_reader_if: wide enqueue handshake plus narrow dequeue
// handshake of the splitter, bundled as one interface.
// Signals:
//   io_enq_bits/io_enq_valid (upstream -> splitter), io_enq_ready (splitter -> upstream)
//   io_deq_bits/io_deq_valid/io_deq_last (splitter -> downstream), io_deq_ready (downstream -> splitter)
// Modports:
//   slave  - splitter view (consumes wide words, produces narrow beats)
//   master - environment view (produces wide words, consumes narrow beats)
interface queue_2048_split_reader_if #(
  parameter int IN_W  = queue_split_pkg::DEF_IN_W,
  parameter int OUT_W = queue_split_pkg::DEF_OUT_W
);
  logic [IN_W-1:0]  io_enq_bits;
  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [OUT_W-1:0] io_deq_bits;
  logic             io_deq_valid;
  logic             io_deq_last;
  logic             io_deq_ready;

  modport slave (
    input  io_enq_bits, io_enq_valid, io_deq_ready,
    output io_enq_ready, io_deq_bits, io_deq_valid, io_deq_last
  );

  modport master (
    output io_enq_bits, io_enq_valid, io_deq_ready,
    input  io_enq_ready, io_deq_bits, io_deq_valid, io_deq_last
  );
endinterface

// File: rtl/queue_2048_split_reader_hold.sv
// split_hold_reg: wide data register with load enable and synchronous
// active-low clear.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-low clear (q <= 0)
//   ld    - load enable
//   d     - data in (W bits)
//   q     - registered data out (W bits)
module split_hold_reg #(
  parameter int W = 2048
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, otherwise load when enabled and hold when not.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/queue_2048_split_reader.sv
// queue_2048_split_reader: drain-side width splitter. Accepts one IN_W-bit
// word over the enq handshake and replays it as IN_W/OUT_W narrow beats over
// the deq handshake, lowest slice first, with io_deq_last on the final slice.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-low reset
//   io    - queue_2048_split_reader_if.slave (enq wide side, deq narrow side)
// Configuration:
//   QUEUE_SPLIT_PREFETCH_EN - adds a one-word prefetch register so the next
//   word is accepted while the current one drains (no bubble between words).
//   Undefined: single holding register, one idle cycle between words.
module queue_2048_split_reader
  import queue_split_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic clock,
  input  logic reset,
  queue_2048_split_reader_if.slave io
);

  localparam int BEATS = beats_f(IN_W, OUT_W);
  localparam int CNT_W = cnt_w_f(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  generate
    if ((IN_W % OUT_W) != 0 || BEATS < 2) begin : g_bad_cfg
      $error("queue_2048_split_reader: IN_W must be a multiple of OUT_W with at least 2 beats");
    end
  endgenerate

  split_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             enq_ready_r, enq_ready_s;
  logic [IN_W-1:0]  hold_q, hold_d_s, hold_src_s;
  logic             hold_ld_s;
  logic             enq_fire_s, deq_fire_s, last_beat_s, next_word_s;

  assign enq_fire_s  = io.io_enq_valid & enq_ready_r;
  assign deq_fire_s  = (state_r == DRAIN) & io.io_deq_ready;
  assign last_beat_s = (cnt_r == CNT_LAST);

  split_hold_reg #(.W(IN_W)) u_hold (
    .clock (clock),
    .reset (reset),
    .ld    (hold_ld_s),
    .d     (hold_d_s),
    .q     (hold_q)
  );

`ifdef QUEUE_SPLIT_PREFETCH_EN
  logic [IN_W-1:0] pre_q;
  logic            pre_ld_s, pre_vld_r, pre_vld_s;

  split_hold_reg #(.W(IN_W)) u_pre (
    .clock (clock),
    .reset (reset),
    .ld    (pre_ld_s),
    .d     (io.io_enq_bits),
    .q     (pre_q)
  );

  // A word arriving during DRAIN parks in pre, unless it lands on the
  // last-beat edge with pre empty, in which case it goes straight to hold.
  always_comb begin
    pre_ld_s  = 1'b0;
    pre_vld_s = pre_vld_r;
    if (enq_fire_s && (state_r == DRAIN) && !(deq_fire_s && last_beat_s)) begin
      pre_ld_s  = 1'b1;
      pre_vld_s = 1'b1;
    end else if (deq_fire_s && last_beat_s && pre_vld_r) begin
      pre_vld_s = 1'b0;
    end else begin
      pre_vld_s = pre_vld_r;
    end
  end

  // Prefetch-valid flag register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_vld_r <= 1'b0;
    end else begin
      pre_vld_r <= pre_vld_s;
    end
  end

  assign next_word_s = pre_vld_r | enq_fire_s;
  assign hold_src_s  = pre_vld_r ? pre_q : io.io_enq_bits;
  assign enq_ready_s = (state_s == IDLE) | ~pre_vld_s;
`else
  assign next_word_s = 1'b0;
  assign hold_src_s  = io.io_enq_bits;
  assign enq_ready_s = (state_s == IDLE);
`endif

  // State register; enq_ready is registered from next state so it never
  // depends combinationally on io_deq_ready, and is held low during reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      enq_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      enq_ready_r <= enq_ready_s;
    end
  end

  // Next-state logic: beat counter advance and hold-register loading.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    hold_ld_s = 1'b0;
    hold_d_s  = io.io_enq_bits;
    case (state_r)
      IDLE: begin
        if (enq_fire_s) begin
          state_s   = DRAIN;
          cnt_s     = '0;
          hold_ld_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (deq_fire_s) begin
          if (last_beat_s) begin
            cnt_s = '0;
            if (next_word_s) begin
              state_s   = DRAIN;
              hold_ld_s = 1'b1;
              hold_d_s  = hold_src_s;
            end else begin
              state_s = IDLE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output logic: everything derives from registered state.
  always_comb begin
    io.io_enq_ready = enq_ready_r;
    io.io_deq_valid = (state_r == DRAIN);
    io.io_deq_last  = (state_r == DRAIN) & last_beat_s;
    io.io_deq_bits  = hold_q[int'(cnt_r)*OUT_W +: OUT_W];
  end

endmodule

// File: tb/tb_queue_2048_split_reader.sv
// tb_queue_2048_split_reader: self-checking bench for queue_2048_split_reader.
// A queue of expected narrow beats is the reference: every accepted wide word
// appends its slices, every downstream transfer pops one. Upstream readiness
// follows from how many words are outstanding versus the buffer capacity
// (1 word, or 2 with QUEUE_SPLIT_PREFETCH_EN). Directed tests add literal
// expectations on cycle timing and specific beat values.
module tb_queue_2048_split_reader;

  localparam int IN_W  = 2048;
  localparam int OUT_W = 256;
  localparam int BEATS = IN_W / OUT_W;
`ifdef QUEUE_SPLIT_PREFETCH_EN
  localparam int CAP  = 2;
  localparam int GAPS = 0;
`else
  localparam int CAP  = 1;
  localparam int GAPS = 1;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  queue_2048_split_reader_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  queue_2048_split_reader #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cur_tag = 0;

  logic [OUT_W-1:0] exp_q[$];
  bit known    = 1'b0;
  bit rst_done = 1'b0;

  int               enq_cyc[$];
  int               deq_cyc[$];
  logic [OUT_W-1:0] deq_val[$];
  int               last_cyc[$];

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d): bound expired", nm, cyc);
  endtask

  function automatic logic [OUT_W-1:0] slice_val(input int tag, input int i);
    logic [7:0] b;
    b = {tag[3:0], i[3:0]};
    return {32{b}};
  endfunction

  function automatic logic [IN_W-1:0] make_word(input int tag);
    logic [IN_W-1:0] w;
    for (int i = 0; i < BEATS; i++) w[i*OUT_W +: OUT_W] = slice_val(tag, i);
    return w;
  endfunction

  // Reference model and per-cycle comparison, mid-cycle when all is stable.
  always @(negedge clock) begin
    bit exp_ready;
    cyc++;
    exp_ready = rst_done && (((exp_q.size() + BEATS - 1) / BEATS) < CAP);
    if (known) begin
      chk("enq_ready", {255'd0, bus.io_enq_ready}, {255'd0, exp_ready});
      chk("deq_valid", {255'd0, bus.io_deq_valid}, {255'd0, exp_q.size() != 0});
      chk("deq_last", {255'd0, bus.io_deq_last}, {255'd0, (exp_q.size() % BEATS) == 1});
      if (exp_q.size() != 0) chk("deq_bits", bus.io_deq_bits, exp_q[0]);
    end
    if (!reset) begin
      exp_q.delete();
      known    = 1'b1;
      rst_done = 1'b0;
    end else if (known) begin
      if (bus.io_deq_valid && bus.io_deq_ready) begin
        deq_cyc.push_back(cyc);
        deq_val.push_back(bus.io_deq_bits);
        if (bus.io_deq_last) last_cyc.push_back(cyc);
      end
      if (bus.io_enq_valid && bus.io_enq_ready) enq_cyc.push_back(cyc);
      if ((exp_q.size() != 0) && bus.io_deq_ready) void'(exp_q.pop_front());
      if (bus.io_enq_valid && exp_ready) begin
        for (int i = 0; i < BEATS; i++) exp_q.push_back(slice_val(cur_tag, i));
      end
      rst_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    enq_cyc.delete();
    deq_cyc.delete();
    deq_val.delete();
    last_cyc.delete();
  endtask

  // Present a word and wait (bounded) until it is accepted; valid stays high.
  task automatic offer(input int tag);
    int  g;
    bit  fired;
    cur_tag = tag;
    bus.io_enq_bits  = make_word(tag);
    bus.io_enq_valid = 1'b1;
    g = 0;
    fired = 1'b0;
    while (!fired && g < 200) begin
      @(negedge clock);
      fired = bus.io_enq_ready;
      g++;
    end
    tick();
    if (!fired) fail_now("enq_accept");
  endtask

  task automatic stop_enq();
    bus.io_enq_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) fail_now("drain");
    tick();
    tick();
  endtask

  initial begin
    logic [OUT_W-1:0] lit;
    int blocked_fire;

    reset = 1'b0;
    bus.io_enq_valid = 1'b0;
    bus.io_enq_bits  = '0;
    bus.io_deq_ready = 1'b0;

    // Reset for 3 cycles, then release.
    repeat (3) tick();
    chk("rst_enq_ready", {255'd0, bus.io_enq_ready}, 256'd0);
    chk("rst_deq_valid", {255'd0, bus.io_deq_valid}, 256'd0);
    chk("rst_deq_last", {255'd0, bus.io_deq_last}, 256'd0);
    chk("rst_deq_bits", bus.io_deq_bits, 256'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_enq_ready", {255'd0, bus.io_enq_ready}, 256'd1);

    // Single word, downstream always ready.
    clear_logs();
    bus.io_deq_ready = 1'b1;
    offer(1);
    stop_enq();
    drain();
    chk("single_fires", 256'(deq_cyc.size()), 256'(BEATS));
    chk("single_lasts", 256'(last_cyc.size()), 256'd1);
    if (enq_cyc.size() == 1 && deq_cyc.size() == BEATS && last_cyc.size() == 1) begin
      for (int i = 0; i < BEATS; i++)
        chk("single_beat_cycle", 256'(deq_cyc[i]), 256'(enq_cyc[0] + 1 + i));
      chk("single_last_cycle", 256'(last_cyc[0]), 256'(enq_cyc[0] + 8));
      lit = {32{8'h10}};
      chk("single_beat0", deq_val[0], lit);
      lit = {32{8'h17}};
      chk("single_beat7", deq_val[7], lit);
    end else begin
      fail_now("single_log_shape");
    end

    // Backpressure: deq_ready pattern 1,0,0,1 repeating.
    begin
      logic [3:0] pat;
      int g;
      pat = 4'b1001;
      clear_logs();
      offer(2);
      stop_enq();
      g = 0;
      while (deq_cyc.size() < BEATS && g < 100) begin
        bus.io_deq_ready = pat[g % 4];
        tick();
        g++;
      end
      if (g >= 100) fail_now("bp_fires");
      bus.io_deq_ready = 1'b1;
      drain();
      chk("bp_fires", 256'(deq_cyc.size()), 256'(BEATS));
      if (deq_val.size() == BEATS) begin
        lit = {32{8'h20}};
        chk("bp_beat0", deq_val[0], lit);
        lit = {32{8'h23}};
        chk("bp_beat3", deq_val[3], lit);
      end else begin
        fail_now("bp_log_shape");
      end
    end

    // Back-to-back: 4 words, continuous valid and ready.
    clear_logs();
    bus.io_deq_ready = 1'b1;
    for (int w = 3; w < 7; w++) offer(w);
    stop_enq();
    drain();
    chk("b2b_fires", 256'(deq_cyc.size()), 256'(4 * BEATS));
    chk("b2b_lasts", 256'(last_cyc.size()), 256'd4);
    if (deq_cyc.size() == 4 * BEATS)
      chk("b2b_span", 256'(deq_cyc[4*BEATS-1] - deq_cyc[0] + 1), 256'(4 * BEATS + 3 * GAPS));
    else
      fail_now("b2b_log_shape");

    // Reset in the middle of a drain, after beat 3 fired.
    begin
      int g;
      clear_logs();
      bus.io_deq_ready = 1'b1;
      offer(7);
      stop_enq();
      g = 0;
      while (deq_cyc.size() < 4 && g < 50) begin
        tick();
        g++;
      end
      if (g >= 50) fail_now("mid_rst_wait");
      reset = 1'b0;
      bus.io_deq_ready = 1'b0;
      tick();
      chk("mid_rst_valid", {255'd0, bus.io_deq_valid}, 256'd0);
      chk("mid_rst_bits", bus.io_deq_bits, 256'd0);
      chk("mid_rst_fires", 256'(deq_cyc.size()), 256'd4);
      chk("mid_rst_lasts", 256'(last_cyc.size()), 256'd0);
      reset = 1'b1;
      tick();
      clear_logs();
      bus.io_deq_ready = 1'b1;
      offer(8);
      stop_enq();
      drain();
      chk("after_rst_fires", 256'(deq_cyc.size()), 256'(BEATS));
      lit = {32{8'h80}};
      if (deq_val.size() != 0) chk("after_rst_beat0", deq_val[0], lit);
      else fail_now("after_rst_beat0");
    end

    // Buffer full while downstream stalls; the blocked word is accepted
    // in the cycle after the first word's last beat fires.
    clear_logs();
    bus.io_deq_ready = 1'b0;
    offer(9);
`ifdef QUEUE_SPLIT_PREFETCH_EN
    offer(10);
    blocked_fire = 11;
`else
    blocked_fire = 10;
`endif
    cur_tag = blocked_fire;
    bus.io_enq_bits  = make_word(blocked_fire);
    bus.io_enq_valid = 1'b1;
    repeat (4) tick();
    chk("full_enq_ready", {255'd0, bus.io_enq_ready}, 256'd0);
    bus.io_deq_ready = 1'b1;
    offer(blocked_fire);
    stop_enq();
    drain();
    if (last_cyc.size() >= 1 && enq_cyc.size() == CAP + 1)
      chk("full_release_cycle", 256'(enq_cyc[CAP]), 256'(last_cyc[0] + 1));
    else
      fail_now("full_log_shape");
    chk("full_fires", 256'(deq_cyc.size()), 256'((CAP + 1) * BEATS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
